mem_model_q_drain: RTL



---
 rtl/mem_model_q_drain.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_model_q_drain.sv
// Drains posted writes {addr, be, data} from a FWFT request queue onto a req/ack
// memory write port, with an ack timeout (sticky err) and a completed-write counter.
module mem_model_q_drain #(
    parameter int ADDRW   = 8,
    parameter int BEW     = 4,
    parameter int DATAW   = 32,
    parameter int WIDTH   = ADDRW + BEW + DATAW,
    parameter int MAXWAIT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_rdata,
    output logic             q_read,
    output logic             mem_wr,
    output logic [ADDRW-1:0] mem_addr,
    output logic [BEW-1:0]   mem_be,
    output logic [DATAW-1:0] mem_wdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             err,
    output logic [15:0]      drained_count
);

    localparam int CNTW = (MAXWAIT < 2) ? 1 : $clog2(MAXWAIT);
    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(MAXWAIT - 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  wait_q, wait_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ADDRW-1:0] addr_q;
    logic [BEW-1:0]   be_q;
    logic [DATAW-1:0] wdata_q;

    logic pop;
    logic ack_ok;
    logic timeout;

    assign ack_ok  = (state_q == ISSUE) && mem_ack;
    assign pop     = !clr && !q_empty && ((state_q == IDLE) || ack_ok);
    assign timeout = (state_q == ISSUE) && !mem_ack && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pop) state_d = ISSUE;
                ISSUE: begin
                    if (mem_ack)      state_d = pop ? ISSUE : IDLE;
                    else if (timeout) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        q_read = pop;
        mem_wr = (state_q == ISSUE);
        busy   = (state_q != IDLE) || !q_empty;
    end

    // Timeout drops the entry without counting it; clr overrides everything.
    always_comb begin
        wait_d = '0;
        err_d  = err_q | timeout;
        cnt_d  = ack_ok ? cnt_q + 16'd1 : cnt_q;
        if ((state_q == ISSUE) && !mem_ack && !timeout) begin
            wait_d = wait_q + CNTW'(1);
        end
        if (clr) begin
            wait_d = '0;
            err_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry fields are captured only on a pop; clr leaves them untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (pop) begin
            wdata_q <= q_rdata[DATAW-1:0];
            be_q    <= q_rdata[DATAW+BEW-1:DATAW];
            addr_q  <= q_rdata[WIDTH-1:DATAW+BEW];
        end
    end

    assign mem_addr      = addr_q;
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;
    assign err           = err_q;
    assign drained_count = cnt_q;

endmodule
